// File: rtl/dram_stream_reader_pkg.sv
// Shared definitions for the DRAM stream reader.
// Provides default widths, the controller state encoding and a helper for
// sizing occupancy counters.
package dram_stream_reader_pkg;

    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_RD_LAT     = 2;
    localparam int DEF_FIFO_DEPTH = DEF_RD_LAT + 1;
    localparam int COUNT_W        = 16;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    localparam int FIFO_CNT_W = cnt_width(DEF_FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } rd_state_t;

endpackage

// File: rtl/dram_return_fifo.sv
// Return-data buffer for the DRAM stream reader.
// Synchronous FIFO of DEPTH x DATA_W. The head entry is presented on
// rd_data directly from storage, so it stays stable until popped.
//   clock, reset       : system clock, async active-high reset
//   push, wr_data      : write one entry
//   pop                : remove head entry (ignored when empty)
//   rd_data            : head entry
//   occupancy          : number of stored entries
//   empty, full        : occupancy == 0 / occupancy == DEPTH
module dram_return_fifo
    import dram_stream_reader_pkg::*;
#(
    parameter int DEPTH  = DEF_FIFO_DEPTH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = cnt_width(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  occupancy,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] storage [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (occupancy == '0);
    assign full    = (occupancy == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO can still accept a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rd_data = storage[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_push) begin
                storage[wr_ptr] <= wr_data;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: rtl/dram_stream_reader.sv
// Strided read initiator for the dual-port matrix DRAM.
// On start it reads count bytes at base, base+stride, ... (mod 2^ADDR_W) and
// streams them out over valid/ready, using a credit scheme so the return
// FIFO can never overflow regardless of downstream backpressure.
//   clock, reset                : system clock, async active-high reset
//   start, base_addr, count,
//   stride                      : transfer command, sampled in IDLE only
//   busy, done                  : transfer status; done is a one-cycle pulse
//   mem_address, mem_data,
//   mem_wren, mem_q             : RAM port (read-only use)
//   out_data, out_valid,
//   out_ready                   : output byte stream
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing reads while credits allow
// DRAIN | all reads issued; waiting for pipe and FIFO to empty
// FIN   | done pulse, back to IDLE next cycle
module dram_stream_reader
    import dram_stream_reader_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_LAT     = DEF_RD_LAT,
    parameter int FIFO_DEPTH = RD_LAT + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [COUNT_W-1:0] count,
    input  logic [ADDR_W-1:0]  stride,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [DATA_W-1:0]  mem_data,
    output logic               mem_wren,
    input  logic [DATA_W-1:0]  mem_q,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int CNT_W = cnt_width(FIFO_DEPTH);

    rd_state_t          state;
    rd_state_t          state_nxt;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  stride_q;
    logic [COUNT_W-1:0] remaining;
    logic [RD_LAT-1:0]  inflight_sr;
    logic [CNT_W-1:0]   occupancy;
    logic               fifo_empty;
    logic               fifo_full;
    logic               issue;
    logic               push;
    logic               pop;
    logic               credit_ok;
    int                 credit_used;

    assign push      = inflight_sr[RD_LAT-1];
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    // Every issued read holds a FIFO slot from issue until it is popped.
    // A pop in this cycle frees its slot in time for a read issued now,
    // which is what sustains one byte per cycle at the minimum depth.
    always_comb begin
        credit_used = $countones(inflight_sr) + int'(occupancy);
        credit_ok   = credit_used < (FIFO_DEPTH + (pop ? 1 : 0));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (count == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                issue = (remaining != '0) && credit_ok;
                if (remaining == '0 || (issue && remaining == COUNT_W'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Finish as the last byte leaves so done lands right after it.
                if (inflight_sr == '0 &&
                    (fifo_empty || (occupancy == CNT_W'(1) && pop))) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // addr_q drives the RAM address directly: it holds the address of the next
    // read and only advances after an issue that is not the last, so the bus
    // never shows an address that is not read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            stride_q    <= '0;
            remaining   <= '0;
            inflight_sr <= '0;
        end else begin
            if (state == IDLE && start) begin
                stride_q  <= stride;
                remaining <= count;
                if (count != '0) begin
                    addr_q <= base_addr;
                end
            end else if (issue) begin
                remaining <= remaining - COUNT_W'(1);
                if (remaining != COUNT_W'(1)) begin
                    addr_q <= addr_q + stride_q;
                end
            end
            inflight_sr[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) begin
                inflight_sr[i] <= inflight_sr[i-1];
            end
        end
    end

    assign busy        = (state != IDLE);
    assign done        = (state == FIN);
    assign mem_address = addr_q;
    assign mem_data    = '0;
    assign mem_wren    = 1'b0;

    dram_return_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .wr_data   (mem_q),
        .pop       (pop),
        .rd_data   (out_data),
        .occupancy (occupancy),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // The credit scheme makes a write into a full FIFO impossible.
    assert property (@(posedge clock) disable iff (reset) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_dram_stream_reader.sv
// Directed bench for dram_stream_reader with a two-cycle-latency RAM model
// and a byte scoreboard filled at each start command.
module tb_dram_stream_reader;

    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = RD_LAT + 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] count = '0;
    logic [15:0] stride = '0;
    logic        out_ready = 1'b1;
    logic        busy, done, mem_wren, out_valid;
    logic [15:0] mem_address;
    logic [7:0]  mem_data, mem_q, out_data;

    int checks = 0;
    int failures = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    int max_occ = 0;
    int max_used = 0;

    logic [7:0]  sb [$];
    logic [7:0]  ram [0:65535];
    logic [15:0] ram_addr_q = '0;
    logic [7:0]  ram_q = '0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;

    dram_stream_reader #(.RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .count       (count),
        .stride      (stride),
        .busy        (busy),
        .done        (done),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clock = ~clock;

    // RAM: address registered, then data registered -> q two cycles after address.
    always @(posedge clock) begin
        ram_addr_q <= mem_address;
        ram_q      <= ram[ram_addr_q];
    end
    assign mem_q = ram_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [15:0] b, input logic [15:0] c, input logic [15:0] s);
        base_addr = b;
        count     = c;
        stride    = s;
        start     = 1'b1;
        for (int i = 0; i < int'(c); i++) begin
            logic [15:0] a;
            a = b + 16'(i) * s;
            sb.push_back(ram[a]);
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        int n = 0;
        while (!done && n < max_cycles) begin
            tick();
            n++;
        end
        check(tag, done, 1);
    endtask

    // Output monitor: scoreboard compare, hold-under-stall, occupancy bounds.
    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            int occ_now;
            int used_now;
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                hs_cnt++;
                check("sb_has_entry", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    check("out_data", out_data, sb.pop_front());
                end
            end
            if (done) done_cnt++;
            occ_now  = int'(dut.u_fifo.occupancy);
            used_now = $countones(dut.inflight_sr) + occ_now;
            if (occ_now > max_occ) max_occ = occ_now;
            if (used_now > max_used) max_used = used_now;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0, dn0, k;
        logic [3:0] pat;

        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        for (int i = 0; i < 6; i++) ram[16'h0100 + 16'(i)] = 8'(i + 1);
        ram[16'hFFFE] = 8'hA1;
        ram[16'h0001] = 8'hA2;
        ram[16'h0004] = 8'hA3;
        for (int i = 0; i < 8; i++) ram[16'h0200 + 16'(i)] = 8'(16 + 17 * i);

        // Reset state
        tick(); tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_mem_wren", mem_wren, 0);
        check("rst_mem_data", mem_data, 0);
        reset = 1'b0;
        tick();

        // Row read: latency, back-to-back output, single done
        dn0 = done_cnt;
        do_start(16'h0100, 16'd4, 16'd1);
        check("row_addr_c1", mem_address, 16'h0100);
        check("row_busy_c1", busy, 1);
        tick(); tick();
        check("row_no_valid_c3", out_valid, 0);
        for (int c = 4; c <= 7; c++) begin
            tick();
            check("row_valid_consecutive", out_valid, 1);
        end
        tick();
        check("row_done_c8", done, 1);
        check("row_busy_c8", busy, 1);
        tick();
        check("row_done_low_c9", done, 0);
        check("row_busy_low_c9", busy, 0);
        check("row_done_pulses", done_cnt - dn0, 1);
        check("row_sb_empty", sb.size(), 0);

        // Column stride with address wrap
        do_start(16'hFFFE, 16'd3, 16'd3);
        check("wrap_addr0", mem_address, 16'hFFFE);
        tick();
        check("wrap_addr1", mem_address, 16'h0001);
        tick();
        check("wrap_addr2", mem_address, 16'h0004);
        wait_done("wrap_done", 40);
        tick();
        check("wrap_sb_empty", sb.size(), 0);
        check("wrap_busy_low", busy, 0);

        // Backpressure: ready pattern 1,0,0,1
        hs0 = hs_cnt;
        max_occ = 0;
        max_used = 0;
        pat = 4'b1001;
        do_start(16'h0200, 16'd8, 16'd1);
        k = 0;
        while (!done && k < 200) begin
            out_ready = pat[k % 4];
            tick();
            k++;
        end
        check("bp_done", done, 1);
        out_ready = 1'b1;
        tick();
        check("bp_handshakes", hs_cnt - hs0, 8);
        check("bp_sb_empty", sb.size(), 0);
        check("bp_max_occ_ok", max_occ <= FIFO_DEPTH, 1);
        check("bp_credit_ok", max_used <= FIFO_DEPTH, 1);

        // Start while busy is ignored
        hs0 = hs_cnt;
        dn0 = done_cnt;
        do_start(16'h0100, 16'd4, 16'd1);
        tick();
        base_addr = 16'h0200;
        count     = 16'd5;
        stride    = 16'd7;
        start     = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ign_done", 40);
        for (int i = 0; i < 5; i++) tick();
        check("ign_handshakes", hs_cnt - hs0, 4);
        check("ign_done_pulses", done_cnt - dn0, 1);
        check("ign_sb_empty", sb.size(), 0);
        check("ign_idle_valid", out_valid, 0);

        // count = 0
        do_start(16'h3000, 16'd0, 16'd1);
        check("zero_done_c1", done, 1);
        check("zero_busy_c1", busy, 1);
        check("zero_addr_c1", mem_address, 16'h0103);
        check("zero_valid_c1", out_valid, 0);
        tick();
        check("zero_done_c2", done, 0);
        check("zero_busy_c2", busy, 0);
        check("zero_addr_c2", mem_address, 16'h0103);
        check("zero_valid_c2", out_valid, 0);

        // Reset during RUN with two reads in flight
        do_start(16'h0100, 16'd6, 16'd1);
        tick(); tick();
        check("mid_inflight", $countones(dut.inflight_sr), 2);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_addr", mem_address, 0);
        sb.delete();
        tick();
        reset = 1'b0;
        dn0 = done_cnt;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_no_valid", out_valid, 0);
            check("post_rst_no_done", done, 0);
        end
        check("post_rst_done_cnt", done_cnt - dn0, 0);
        hs0 = hs_cnt;
        do_start(16'h0100, 16'd2, 16'd1);
        wait_done("restart_done", 40);
        tick();
        check("restart_handshakes", hs_cnt - hs0, 2);
        check("restart_sb_empty", sb.size(), 0);
        check("restart_busy_low", busy, 0);
        check("final_mem_wren", mem_wren, 0);
        check("final_mem_data", mem_data, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
